// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and constants for the SPI word sequencer
//
// Contents:
//   DEFAULT_DW   default data word width, matching the 12-bit SPI master
//   seq_state_t  sequencer states: IDLE, LAUNCH, WAIT_DONE
package spi_seq_pkg;

    localparam int DEFAULT_DW = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - synchronous word FIFO feeding the SPI sequencer
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   push, wr_data   write request and data; dropped when full unless a pop happens in the same cycle
//   pop, rd_data    read request and combinational head word
//   full, empty     occupancy flags
//   level           number of stored words, 0..DEPTH
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra bit so that equal low bits with different
    // MSBs mean full, while fully equal pointers mean empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push alongside it
    // is accepted even when full; the head is read before the write lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_word_sequencer.sv
// rtl/spi_word_sequencer.sv - queues host words and runs them one by one through the SPI master
//
// Ports:
//   clk, rst                    clock shared with the SPI master; asynchronous active-low reset
//   wr_en, wr_data, full, level host push side of the word FIFO
//   m_newd, m_din               launch handshake towards the master
//   m_sclk, m_done, m_dout      master serial clock, completion pulse and received word
//   rd_valid, rd_data, rd_ready result port, one word per completed transfer
//   busy                        a transfer is in flight
//   ovf_err, to_err, clr_err    sticky overflow / timeout flags and their clear
module spi_word_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DW          = DEFAULT_DW,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   m_newd,
    output logic [DW-1:0]          m_din,
    input  logic                   m_sclk,
    input  logic                   m_done,
    input  logic [DW-1:0]          m_dout,
    output logic                   rd_valid,
    output logic [DW-1:0]          rd_data,
    input  logic                   rd_ready,
    output logic                   busy,
    output logic                   ovf_err,
    output logic                   to_err,
    input  logic                   clr_err
);

    localparam int              TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic          timer_hit;
    logic          sclk_q;
    logic          done_q;
    logic          sclk_rise;
    logic          done_rise;
    logic          fifo_empty;
    logic [DW-1:0] head;
    logic          launch;
    logic          handoff;
    logic          capture;
    logic          abort;
    logic          ovf_set;

    spi_seq_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (launch),
        .rd_data (head),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign sclk_rise = m_sclk && !sclk_q;
    assign done_rise = m_done && !done_q;
    assign timer_hit = (timer == TIMER_LAST);
    assign busy      = (state != IDLE);
    assign ovf_set   = wr_en && full && !launch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Progress wins over the timeout: an sclk or done rise seen in the
    // timer's last cycle still advances the transfer normally.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        handoff   = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // An unconsumed result holds off the next launch.
                if (!fifo_empty && !rd_valid) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (sclk_rise) begin
                    handoff   = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (timer_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (timer_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sclk_q <= m_sclk;
            done_q <= m_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (launch || capture || abort) begin
            timer <= '0;
        end else if (state != IDLE) begin
            timer <= timer + 1'b1;
        end
    end

    // m_din is held after the launch so the master may sample it late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_newd <= 1'b0;
            m_din  <= '0;
        end else if (launch) begin
            m_newd <= 1'b1;
            m_din  <= head;
        end else if (handoff || abort) begin
            m_newd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (capture) begin
            rd_valid <= 1'b1;
            rd_data  <= m_dout;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            to_err  <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end
            if (abort) begin
                to_err <= 1'b1;
            end else if (clr_err) begin
                to_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// tb/tb_spi_word_sequencer.sv - scoreboard bench for spi_word_sequencer
`timescale 1ns/1ps
module tb_spi_word_sequencer;

    localparam int             DW    = 12;
    localparam int             DEPTH = 8;
    localparam int             TMO   = 16;
    localparam logic [DW-1:0]  XMASK = 12'h5A5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          full;
    logic [3:0]    level;
    logic          m_newd;
    logic [DW-1:0] m_din;
    logic          m_sclk   = 1'b0;
    logic          m_done   = 1'b0;
    logic [DW-1:0] m_dout   = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic          busy;
    logic          ovf_err;
    logic          to_err;
    logic          clr_err  = 1'b0;

    // Reference model: words expected on m_din in launch order, and the
    // results the consumer should receive in order.
    logic [DW-1:0] launch_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_checks   = 0;
    int            n_pass     = 0;
    int            result_cnt = 0;
    int            mmode      = 0;   // 0 normal, 1 silent master, 2 sclk but never done
    bit            hold_ready = 1'b0;
    bit            rand_ready = 1'b0;
    bit            newd_seen  = 1'b0;

    always #5 clk = ~clk;

    spi_word_sequencer #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .m_newd   (m_newd),
        .m_din    (m_din),
        .m_sclk   (m_sclk),
        .m_done   (m_done),
        .m_dout   (m_dout),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .busy     (busy),
        .ovf_err  (ovf_err),
        .to_err   (to_err),
        .clr_err  (clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit accept, input bit want_result);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = w;
        if (accept) begin
            launch_q.push_back(w);
            if (want_result) exp_q.push_back(w ^ XMASK);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((launch_q.size() != 0 || exp_q.size() != 0 || busy || level != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 32'(n < 2000), 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Behavioural SPI master: answers each launch with the word XOR XMASK.
    always begin : master_model
        logic [DW-1:0] cap;
        int            n;
        @(negedge clk);
        if (rst && m_newd && !newd_seen) begin
            newd_seen = 1'b1;
            if (launch_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_launch: m_din=%h with no word queued", m_din);
            end else begin
                chk("m_din", 32'(m_din), 32'(launch_q.pop_front()));
            end
            cap = m_din;
            if (mmode == 1) begin
                n = 0;
                while (m_newd && n < 64) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_len", n, TMO);
                chk("to_err_set", 32'(to_err), 1);
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                m_sclk = 1'b1;
                @(negedge clk);
                m_sclk = 1'b0;
                if (mmode == 0) begin
                    repeat ($urandom_range(2, 5)) @(negedge clk);
                    m_dout = cap ^ XMASK;
                    m_done = 1'b1;
                    @(negedge clk);
                    m_done = 1'b0;
                    m_dout = DW'($urandom);
                    chk("rd_valid_latency", 32'(rd_valid), 1);
                    chk("rd_data_capture", 32'(rd_data), 32'(cap ^ XMASK));
                end
            end
        end
        if (!m_newd) newd_seen = 1'b0;
    end

    // Consumer: drives rd_ready and pops the scoreboard on each handshake.
    always begin : result_monitor
        @(negedge clk);
        if (hold_ready)      rd_ready = 1'b0;
        else if (rand_ready) rd_ready = ($urandom_range(0, 3) != 0);
        else                 rd_ready = 1'b1;
        if (rst && rd_valid && rd_ready) begin
            result_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_result: rd_data=%h with no result expected", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] w;
        int            r0;
        int            n;

        repeat (3) @(negedge clk);
        chk("rst_newd", 32'(m_newd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_errs", {ovf_err, to_err}, 0);
        chk("rst_din", 32'(m_din), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed first word with launch latency.
        push_word(12'hA5C, 1'b1, 1'b1);
        chk("lat_level", 32'(level), 1);
        chk("lat_newd_early", 32'(m_newd), 0);
        @(negedge clk);
        chk("lat_newd", 32'(m_newd), 1);
        chk("lat_din", 32'(m_din), 32'h0A5C);
        chk("lat_busy", 32'(busy), 1);
        chk("lat_level_pop", 32'(level), 0);
        wait_drain("a5c");

        // Five random words, consumer always ready.
        r0 = result_cnt;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_word(DW'($urandom), 1'b1, 1'b1);
        end
        wait_drain("burst5");
        chk("burst5_count", result_cnt - r0, 5);
        chk("burst5_errs", {ovf_err, to_err}, 0);

        // Sixteen random words with a stuttering consumer; never overfill.
        rand_ready = 1'b1;
        r0 = result_cnt;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (exp_q.size() >= DEPTH && n < 500) begin
                @(negedge clk);
                n++;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_word(DW'($urandom), 1'b1, 1'b1);
        end
        wait_drain("stutter");
        chk("stutter_count", result_cnt - r0, 16);
        rand_ready = 1'b0;

        // Pending result blocks launches; fill the FIFO and overflow it.
        hold_ready = 1'b1;
        push_word(DW'($urandom), 1'b1, 1'b1);
        n = 0;
        while (!rd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_result", 32'(rd_valid), 1);
        for (int i = 0; i < 9; i++) begin
            w = DW'($urandom);
            push_word(w, i < 8, 1'b1);
            chk("fill_level", 32'(level), (i < 8) ? i + 1 : 8);
            chk("fill_full", 32'(full), 32'(i >= 7));
            chk("blocked_newd", 32'(m_newd), 0);
        end
        chk("ovf_set", 32'(ovf_err), 1);
        @(negedge clk);
        clr_err = 1'b1;
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        @(negedge clk);
        clr_err = 1'b0;
        wr_en   = 1'b0;
        chk("ovf_set_wins", 32'(ovf_err), 1);
        pulse_clr();
        chk("ovf_clear", 32'(ovf_err), 0);
        chk("held_level", 32'(level), 8);
        hold_ready = 1'b0;
        wait_drain("ovf");

        // Silent master: both words time out without results.
        mmode = 1;
        push_word(DW'($urandom), 1'b1, 1'b0);
        push_word(DW'($urandom), 1'b1, 1'b0);
        wait_drain("timeout");
        chk("to_sticky", 32'(to_err), 1);
        chk("to_no_result", 32'(rd_valid), 0);
        pulse_clr();
        chk("to_clear", 32'(to_err), 0);

        // Reset in WAIT_DONE drops everything at once.
        mmode = 2;
        push_word(DW'($urandom), 1'b1, 1'b0);
        push_word(DW'($urandom), 1'b1, 1'b0);
        push_word(DW'($urandom), 1'b1, 1'b0);
        n = 0;
        while (!(busy && !m_newd) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_done", 32'(n < 50), 1);
        chk("pre_reset_level", 32'(level), 2);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_newd", 32'(m_newd), 0);
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_level", 32'(level), 0);
        launch_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        mmode = 0;
        rst   = 1'b1;
        push_word(DW'($urandom), 1'b1, 1'b1);
        wait_drain("post_reset");
        chk("post_reset_errs", {ovf_err, to_err}, 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_word_sequencer.md
Name: spi_word_sequencer

Overview:
- Upstream/downstream companion to the 12-bit SPI master (spi_design / s1).
- Buffers host words in a small FIFO and launches each one on the master with the newd/din handshake.
- Waits for the master's done pulse, captures dout, and presents it on a valid/ready result port.
- Sits between the host-side register logic and the SPI master so that back-to-back transfers need no testbench-style sequencing.

Parameters:
- DW, 12, data word width; matches the master din/dout.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYC, 4096, clk cycles allowed in LAUNCH+WAIT_DONE before abort; minimum 16.

Ports:
- clk  in  1  system clock; same clock as the SPI master.
- rst  in  1  asynchronous reset, active-low; asserted when 0.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  DW  host word to transmit.
- full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- m_newd  out  1  newd to the master.
- m_din  out  DW  din to the master.
- m_sclk  in  1  master sclk; clk-synchronous and sampled directly.
- m_done  in  1  master done.
- m_dout  in  DW  master received word.
- rd_valid  out  1  result word available.
- rd_data  out  DW  captured m_dout.
- rd_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.
- ovf_err  out  1  sticky; a push was attempted while full.
- to_err  out  1  sticky; a transfer timed out.
- clr_err  in  1  synchronous clear of ovf_err and to_err.

Behaviour:
- Reset (rst=0, async): all outputs are 0, FIFO pointers are 0, state is IDLE, and the timeout counter is 0.
- FIFO:
  - A push while full is dropped and sets ovf_err.
  - Pop occurs only on the IDLE->LAUNCH transition.
  - A simultaneous push and pop keeps level unchanged and is legal when full.
  - Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty; wrap is natural.
- Edge detection: registered copies of m_sclk and m_done; rise = current & ~previous.
- State machine:
  - IDLE: if level!=0 and rd_valid==0, pop the head into m_din (m_din is registered and holds until the next launch), set m_newd=1, clear the timer, go to LAUNCH. A pending unconsumed result blocks the launch.
  - LAUNCH: m_newd stays 1 until an m_sclk rise; on that cycle m_newd->0 next edge and the state goes to WAIT_DONE.
  - WAIT_DONE: on an m_done rise, rd_data<=m_dout, rd_valid<=1, go to IDLE.
  - Timeout: the timer increments in LAUNCH and WAIT_DONE. On reaching TIMEOUT_CYC-1, m_newd<=0, to_err<=1, the word is discarded with no result, and the state returns to IDLE.
- Result port: rd_valid clears on rd_valid&rd_ready. The earliest next launch is the IDLE cycle following the clear.
- Latency: the m_newd rise occurs 1 clk after the word is resident at the head in IDLE with rd_valid=0. rd_valid rises 1 clk after the m_done rise.
- Simultaneous events:
  - m_done rise in the same cycle as the timeout: done wins and the result is captured.
  - clr_err with a new error event in the same cycle: set wins.
- Reset mid-transfer: everything returns to reset values immediately. m_newd drops asynchronously and FIFO contents are lost.
- busy = (state!=IDLE); combinational from the state register.

Decomposition:
- Package spi_seq_pkg: state enum (IDLE, LAUNCH, WAIT_DONE) and the default DW constant.
- One natural sub-module: spi_seq_fifo, a parameterised synchronous FIFO with push/pop/full/empty/level.
- Sequencer FSM, edge detectors, timer and result register stay in the top level.

Test Plan:
- Reset then push 12'hA5C -> m_newd=1 with m_din=12'hA5C; after done, rd_valid=1 with rd_data equal to the master loopback value; level returns to 0.
- Push 5 random words with rd_ready held 1 -> exactly 5 transfers in push order, 5 rd_valid pulses, no errors.
- Push 9 words with DEPTH=8 and the master stalled -> full=1 after 8, 9th push dropped, ovf_err=1; clr_err clears it.
- Hold rd_ready=0 after the first result with 2 words queued -> no second launch; m_newd stays 0 until rd_ready pulses, then launch.
- Model with no sclk/done, TIMEOUT_CYC=16 -> m_newd drops at cycle 16, to_err=1, rd_valid stays 0, next queued word launches.
- Assert rst=0 in WAIT_DONE -> busy, m_newd and rd_valid are 0 immediately, level=0, and normal operation resumes after release.
